ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the 5-stage pipeline. It consumes the ID/EX pipeline register outputs and resolves operand forwarding from EX/MEM and MEM/WB. It runs the ALU, or an optional iterative multiplier, and resolves BEQ. Results, store data, destination register and surviving control signals are registered into the EX/MEM boundary, so this block owns the EX/MEM register.

## Interface
Parameters: none (widths fixed at 32-bit data, 5-bit register index).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- reg_dst_in, alu_src_in, mem_to_reg_in, reg_write_in, mem_read_in, mem_write_in, branch_in  in  1 each  ID/EX control
- alu_ctrl_in  in  3  ALU op from ID/EX
- pc_plus4_in, rd1_in, rd2_in, sign_ext_imm_in  in  32 each  ID/EX data
- rs_in, rt_in, rd_in  in  5 each  ID/EX register indices
- memwb_reg_write_in  in  1  MEM/WB write enable, for forwarding
- memwb_write_reg_in  in  5  MEM/WB destination
- memwb_write_data_in  in  32  MEM/WB write-back value
- reg_write_out, mem_to_reg_out, mem_read_out, mem_write_out  out  1 each  EX/MEM control
- alu_result_out  out  32  EX/MEM result
- store_data_out  out  32  forwarded rt value for stores
- write_reg_out  out  5  EX/MEM destination
- branch_taken_out  out  1  registered; one-cycle pulse; IF redirects and flushes IF/ID and ID/EX
- branch_target_out  out  32  registered target, valid with branch_taken_out
- stall_out  out  1  combinational; upstream holds PC, IF/ID and ID/EX while high

## Operation
- Operand A: forwarded rs. Operand B: forwarded rt, or sign_ext_imm_in if alu_src_in.
- Forwarding for rs and rt applies this priority:
  - EX/MEM, when reg_write_out and write_reg_out == index and index != 0.
  - MEM/WB, under the same conditions.
  - Otherwise the ID/EX value.
  - Register 0 is never forwarded.
- alu_ctrl encoding:
  - 000 AND, 001 OR, 010 ADD, 110 SUB, 100 NOR, 101 XOR.
  - 111 SLT: signed; result 32'd1 or 32'd0.
  - 011 MUL: low 32 bits; see Configuration.
- ADD, SUB and MUL wrap modulo 2^32; no overflow detection.
- write_reg = reg_dst_in ? rd_in : rt_in. store_data = forwarded rt (never the immediate).
- BEQ: when branch_in and forwarded rs == forwarded rt, register branch_taken_out=1 and branch_target_out = pc_plus4_in + (sign_ext_imm_in << 2), modulo 2^32.
  - A branch never writes registers or memory.
- Wrong-path kill: while branch_taken_out is high, the instruction currently in EX is treated as a bubble.
  - All EX/MEM control outputs are captured as 0.
  - No branch is evaluated and no MUL is started.
- Bubble: all EX/MEM control outputs 0. Data outputs are don't-care but deterministic (they capture the computed values).
- Multiplier FSM (EX_MUL_EN only): IDLE → BUSY → DONE → IDLE.
  - IDLE: a valid MUL is in EX and not killed. stall_out=1, operands latched, count=0, go to BUSY. EX/MEM captures a bubble.
  - BUSY: one shift-add step per cycle; stall_out=1; EX/MEM captures bubbles; at count==31 go to DONE.
  - DONE: stall_out=0; EX/MEM captures the product with the held ID/EX controls; go to IDLE.

## Timing
- Non-MUL ops: single cycle; inputs present in cycle T appear on EX/MEM outputs after edge T+1.
- branch_taken_out and branch_target_out are high for exactly the cycle after edge T+1, then return to 0.
- MUL entering EX at cycle T:
  - stall_out is high for cycles T..T+32 (33 cycles).
  - The product is registered at the edge ending cycle T+33.
  - EX/MEM carries bubbles for edges T+1..T+33 exclusive of the final one.
- Back-to-back MULs: the second starts in the cycle after DONE (IDLE check). No overlap.
- Reset (reset_n=0 at an edge):
  - All outputs go to 0 (branch_target_out=0, alu_result_out=0) and the FSM goes to IDLE.
  - This applies mid-multiply: the operation is aborted and stall_out drops in the next cycle.

## Configuration
- EX_MUL_EN defined: multiplier FSM and 011 MUL are present.
- EX_MUL_EN undefined:
  - No FSM; stall_out is tied 0.
  - alu_ctrl 011 yields alu_result 32'd0 with the controls passed unchanged.

## Structure
- Shared package ex_pkg:
  - ALU op localparams: ALU_AND, ALU_OR, ALU_ADD, ALU_MUL, ALU_NOR, ALU_XOR, ALU_SUB, ALU_SLT.
  - Multiplier state encoding: MUL_IDLE, MUL_BUSY, MUL_DONE.
  - Forward-select constants: FWD_NONE, FWD_EXMEM, FWD_MEMWB.
- One sub-module ex_mul_iter: shift-add multiplier with start/busy/done, instantiated only under EX_MUL_EN.
- Forwarding, ALU, branch and the EX/MEM register live in ex_stage.

## Test plan
- ADD with EX/MEM forward: previous instruction wrote r3=5, now rs=3, rd1_in=0, rt value 7 → alu_result_out=12.
- Priority: EX/MEM writes r4=9, MEM/WB writes r4=2, rs=4, ADD with imm 1 → result 10. Repeat with index 0 and both writes → ID/EX value used.
- BEQ taken: rs=rt=7, pc_plus4_in=0x100, imm=4 → branch_taken_out=1 for one cycle, target 0x110. The next instruction (reg_write=1) exits with reg_write_out=0.
- SLT signed: A=0xFFFFFFFF, B=1 → 1. SUB 0-1 → 0xFFFFFFFF.
- MUL (EX_MUL_EN): 6×7 → stall_out high 33 cycles, then alu_result_out=42 with reg_write_out=1. 0xFFFFFFFF×2 → 0xFFFFFFFE.
- Reset during BUSY cycle 10: FSM goes to IDLE, all outputs 0, stall_out=0 next cycle. A subsequent ADD completes in 1 cycle.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU opcodes,
// multiplier states and forwarding selection.
package ex_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_MUL = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        MUL_IDLE,
        MUL_BUSY,
        MUL_DONE
    } mul_state_t;

    typedef enum logic [1:0] {
        FWD_NONE,
        FWD_EXMEM,
        FWD_MEMWB
    } fwd_sel_t;

    // Youngest writer wins; r0 is hardwired and never forwarded.
    function automatic fwd_sel_t fwd_pick(
        input logic [4:0] idx,
        input logic       exm_we,
        input logic [4:0] exm_reg,
        input logic       wb_we,
        input logic [4:0] wb_reg
    );
        if (idx == 5'd0)
            return FWD_NONE;
        if (exm_we && exm_reg == idx)
            return FWD_EXMEM;
        if (wb_we && wb_reg == idx)
            return FWD_MEMWB;
        return FWD_NONE;
    endfunction

endpackage

// File: rtl/ex_mul_iter.sv
// Iterative 32-step shift-add multiplier, low 32 bits of product.
// busy covers the start cycle plus all step cycles; done is one cycle.
module ex_mul_iter
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);

    mul_state_t  state;
    mul_state_t  state_nx;
    logic [4:0]  count;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [31:0] acc;

    // state register
    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= MUL_IDLE;
        else
            state <= state_nx;
    end

    // next state and handshake outputs
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            MUL_IDLE: begin
                if (start) begin
                    busy     = 1'b1;
                    state_nx = MUL_BUSY;
                end
            end
            MUL_BUSY: begin
                busy = 1'b1;
                if (count == 5'd31)
                    state_nx = MUL_DONE;
            end
            MUL_DONE: begin
                done     = 1'b1;
                state_nx = MUL_IDLE;
            end
            default: state_nx = MUL_IDLE;
        endcase
    end

    // operand latch on start, then one shift-add step per busy cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count  <= 5'd0;
            mcand  <= 32'd0;
            mplier <= 32'd0;
            acc    <= 32'd0;
        end else if (state == MUL_IDLE && start) begin
            count  <= 5'd0;
            mcand  <= op_a;
            mplier <= op_b;
            acc    <= 32'd0;
        end else if (state == MUL_BUSY) begin
            if (mplier[0])
                acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 5'd1;
        end
    end

    assign product = acc;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: forwarding, ALU, BEQ resolution and the EX/MEM register.
// Define EX_MUL_EN to build in the iterative multiplier (alu_ctrl 011).
module ex_stage
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        reg_dst_in,
    input  logic        alu_src_in,
    input  logic        mem_to_reg_in,
    input  logic        reg_write_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        branch_in,
    input  logic [2:0]  alu_ctrl_in,
    input  logic [31:0] pc_plus4_in,
    input  logic [31:0] rd1_in,
    input  logic [31:0] rd2_in,
    input  logic [31:0] sign_ext_imm_in,
    input  logic [4:0]  rs_in,
    input  logic [4:0]  rt_in,
    input  logic [4:0]  rd_in,
    input  logic        memwb_reg_write_in,
    input  logic [4:0]  memwb_write_reg_in,
    input  logic [31:0] memwb_write_data_in,
    output logic        reg_write_out,
    output logic        mem_to_reg_out,
    output logic        mem_read_out,
    output logic        mem_write_out,
    output logic [31:0] alu_result_out,
    output logic [31:0] store_data_out,
    output logic [4:0]  write_reg_out,
    output logic        branch_taken_out,
    output logic [31:0] branch_target_out,
    output logic        stall_out
);

    fwd_sel_t    sel_a;
    fwd_sel_t    sel_b;
    logic [31:0] fwd_a;
    logic [31:0] fwd_b;
    logic [31:0] op_b;
    logic [31:0] alu_y;
    logic [31:0] result;
    logic [31:0] target;
    logic [4:0]  write_reg;
    logic        kill;
    logic        hold;
    logic        take;
    logic        bubble;

    // the instruction behind a taken branch is on the wrong path
    assign kill = branch_taken_out;

    assign sel_a = fwd_pick(rs_in, reg_write_out, write_reg_out,
                            memwb_reg_write_in, memwb_write_reg_in);
    assign sel_b = fwd_pick(rt_in, reg_write_out, write_reg_out,
                            memwb_reg_write_in, memwb_write_reg_in);

    // forwarding muxes for both source operands
    always_comb begin
        fwd_a = rd1_in;
        fwd_b = rd2_in;
        unique case (sel_a)
            FWD_EXMEM: fwd_a = alu_result_out;
            FWD_MEMWB: fwd_a = memwb_write_data_in;
            default:   fwd_a = rd1_in;
        endcase
        unique case (sel_b)
            FWD_EXMEM: fwd_b = alu_result_out;
            FWD_MEMWB: fwd_b = memwb_write_data_in;
            default:   fwd_b = rd2_in;
        endcase
    end

    assign op_b = alu_src_in ? sign_ext_imm_in : fwd_b;

    // single-cycle ALU; MUL is produced by the multiplier, not here
    always_comb begin
        alu_y = 32'd0;
        unique case (alu_ctrl_in)
            ALU_AND: alu_y = fwd_a & op_b;
            ALU_OR:  alu_y = fwd_a | op_b;
            ALU_ADD: alu_y = fwd_a + op_b;
            ALU_SUB: alu_y = fwd_a - op_b;
            ALU_NOR: alu_y = ~(fwd_a | op_b);
            ALU_XOR: alu_y = fwd_a ^ op_b;
            ALU_SLT: alu_y = {31'd0, $signed(fwd_a) < $signed(op_b)};
            default: alu_y = 32'd0;
        endcase
    end

`ifdef EX_MUL_EN
    logic        is_mul;
    logic        mul_busy;
    logic        mul_done;
    logic [31:0] mul_p;

    assign is_mul = (alu_ctrl_in == ALU_MUL) && !kill;

    ex_mul_iter u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (is_mul),
        .op_a    (fwd_a),
        .op_b    (op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_p)
    );

    assign stall_out = mul_busy;
    assign hold      = mul_busy;
    assign result    = mul_done ? mul_p : alu_y;
`else
    assign stall_out = 1'b0;
    assign hold      = 1'b0;
    assign result    = alu_y;
`endif

    assign take      = branch_in && !kill && (fwd_a == fwd_b);
    assign target    = pc_plus4_in + (sign_ext_imm_in << 2);
    assign bubble    = kill || branch_in || hold;
    assign write_reg = reg_dst_in ? rd_in : rt_in;

    // EX/MEM pipeline register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            reg_write_out     <= 1'b0;
            mem_to_reg_out    <= 1'b0;
            mem_read_out      <= 1'b0;
            mem_write_out     <= 1'b0;
            alu_result_out    <= 32'd0;
            store_data_out    <= 32'd0;
            write_reg_out     <= 5'd0;
            branch_taken_out  <= 1'b0;
            branch_target_out <= 32'd0;
        end else begin
            reg_write_out     <= reg_write_in && !bubble;
            mem_to_reg_out    <= mem_to_reg_in && !bubble;
            mem_read_out      <= mem_read_in && !bubble;
            mem_write_out     <= mem_write_in && !bubble;
            alu_result_out    <= result;
            store_data_out    <= fwd_b;
            write_reg_out     <= write_reg;
            branch_taken_out  <= take;
            branch_target_out <= take ? target : 32'd0;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Randomized and directed bench for ex_stage against a
// behavioural reference of the execute stage.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        reg_dst_in = 1'b0;
    logic        alu_src_in = 1'b0;
    logic        mem_to_reg_in = 1'b0;
    logic        reg_write_in = 1'b0;
    logic        mem_read_in = 1'b0;
    logic        mem_write_in = 1'b0;
    logic        branch_in = 1'b0;
    logic [2:0]  alu_ctrl_in = 3'd0;
    logic [31:0] pc_plus4_in = 32'd0;
    logic [31:0] rd1_in = 32'd0;
    logic [31:0] rd2_in = 32'd0;
    logic [31:0] sign_ext_imm_in = 32'd0;
    logic [4:0]  rs_in = 5'd0;
    logic [4:0]  rt_in = 5'd0;
    logic [4:0]  rd_in = 5'd0;
    logic        memwb_reg_write_in = 1'b0;
    logic [4:0]  memwb_write_reg_in = 5'd0;
    logic [31:0] memwb_write_data_in = 32'd0;
    logic        reg_write_out;
    logic        mem_to_reg_out;
    logic        mem_read_out;
    logic        mem_write_out;
    logic [31:0] alu_result_out;
    logic [31:0] store_data_out;
    logic [4:0]  write_reg_out;
    logic        branch_taken_out;
    logic [31:0] branch_target_out;
    logic        stall_out;

    int total = 0;
    int bad = 0;

    // reference copy of what EX/MEM should hold
    logic        m_rw, m_mtr, m_mr, m_mw, m_bt;
    logic [31:0] m_res, m_sd, m_tg;
    logic [4:0]  m_wr;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .reg_dst_in          (reg_dst_in),
        .alu_src_in          (alu_src_in),
        .mem_to_reg_in       (mem_to_reg_in),
        .reg_write_in        (reg_write_in),
        .mem_read_in         (mem_read_in),
        .mem_write_in        (mem_write_in),
        .branch_in           (branch_in),
        .alu_ctrl_in         (alu_ctrl_in),
        .pc_plus4_in         (pc_plus4_in),
        .rd1_in              (rd1_in),
        .rd2_in              (rd2_in),
        .sign_ext_imm_in     (sign_ext_imm_in),
        .rs_in               (rs_in),
        .rt_in               (rt_in),
        .rd_in               (rd_in),
        .memwb_reg_write_in  (memwb_reg_write_in),
        .memwb_write_reg_in  (memwb_write_reg_in),
        .memwb_write_data_in (memwb_write_data_in),
        .reg_write_out       (reg_write_out),
        .mem_to_reg_out      (mem_to_reg_out),
        .mem_read_out        (mem_read_out),
        .mem_write_out       (mem_write_out),
        .alu_result_out      (alu_result_out),
        .store_data_out      (store_data_out),
        .write_reg_out       (write_reg_out),
        .branch_taken_out    (branch_taken_out),
        .branch_target_out   (branch_target_out),
        .stall_out           (stall_out)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] idx,
                                        input logic [31:0] idex);
        if (idx != 5'd0 && m_rw && m_wr == idx)
            return m_res;
        if (idx != 5'd0 && memwb_reg_write_in && memwb_write_reg_in == idx)
            return memwb_write_data_in;
        return idex;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b100:  return ~(a | b);
            3'b101:  return a ^ b;
            3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_zero();
        m_rw = 0; m_mtr = 0; m_mr = 0; m_mw = 0; m_bt = 0;
        m_res = 0; m_sd = 0; m_tg = 0; m_wr = 0;
    endtask

    task automatic cmp_all(input string tag);
        check({tag, "_rw"},  32'(reg_write_out),     32'(m_rw));
        check({tag, "_mtr"}, 32'(mem_to_reg_out),    32'(m_mtr));
        check({tag, "_mr"},  32'(mem_read_out),      32'(m_mr));
        check({tag, "_mw"},  32'(mem_write_out),     32'(m_mw));
        check({tag, "_res"}, alu_result_out,         m_res);
        check({tag, "_sd"},  store_data_out,         m_sd);
        check({tag, "_wr"},  32'(write_reg_out),     32'(m_wr));
        check({tag, "_bt"},  32'(branch_taken_out),  32'(m_bt));
        check({tag, "_tg"},  branch_target_out,      m_tg);
    endtask

    // one single-cycle instruction through EX, checked against the model
    task automatic tick(input string tag);
        logic [31:0] a, b, ob, res;
        logic kill, take, bub;
        kill = m_bt;
        a    = fwd(rs_in, rd1_in);
        b    = fwd(rt_in, rd2_in);
        ob   = alu_src_in ? sign_ext_imm_in : b;
        res  = alu_ref(alu_ctrl_in, a, ob);
        take = !kill && branch_in && (a == b);
        bub  = kill || branch_in;
        #1;
        check({tag, "_stall"}, 32'(stall_out), 32'd0);
        @(posedge clk);
        #1;
        m_rw  = reg_write_in && !bub;
        m_mtr = mem_to_reg_in && !bub;
        m_mr  = mem_read_in && !bub;
        m_mw  = mem_write_in && !bub;
        m_res = res;
        m_sd  = b;
        m_wr  = reg_dst_in ? rd_in : rt_in;
        m_bt  = take;
        m_tg  = take ? pc_plus4_in + (sign_ext_imm_in << 2) : 32'd0;
        cmp_all(tag);
    endtask

    task automatic issue(input logic [2:0] op, input logic [4:0] a_rs,
                         input logic [31:0] a_rd1, input logic [4:0] a_rt,
                         input logic [31:0] a_rd2, input logic src,
                         input logic [31:0] imm, input logic rw,
                         input logic [4:0] a_rd, input logic br);
        alu_ctrl_in = op;
        rs_in = a_rs; rd1_in = a_rd1;
        rt_in = a_rt; rd2_in = a_rd2;
        alu_src_in = src; sign_ext_imm_in = imm;
        reg_write_in = rw; reg_dst_in = 1'b1; rd_in = a_rd;
        branch_in = br;
        mem_to_reg_in = 0; mem_read_in = 0; mem_write_in = 0;
        pc_plus4_in = 32'h100;
        memwb_reg_write_in = 0; memwb_write_reg_in = 0;
        memwb_write_data_in = 0;
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        issue(3'b010, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        model_zero();
        cmp_all(tag);
        check({tag, "_stall"}, 32'(stall_out), 32'd0);
        reset_n = 1'b1;
    endtask

`ifdef EX_MUL_EN
    task automatic mul_run(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] want;
        want = a * b;
        issue(3'b011, 5'd1, a, 5'd2, b, 0, 0, 1, 5'd5, 0);
        for (int i = 0; i < 33; i++) begin
            #1;
            check("mul_stall", 32'(stall_out), 32'd1);
            @(posedge clk);
            #1;
            check("mul_bubble", 32'(reg_write_out), 32'd0);
        end
        #1;
        check("mul_done_stall", 32'(stall_out), 32'd0);
        @(posedge clk);
        #1;
        check("mul_prod", alu_result_out, want);
        check("mul_rw", 32'(reg_write_out), 32'd1);
        check("mul_wr", 32'(write_reg_out), 32'd5);
        model_zero();
        m_rw = 1; m_res = want; m_sd = b; m_wr = 5'd5;
    endtask
`endif

    initial begin
        logic [2:0] op;
        model_zero();
        repeat (2) @(posedge clk);
        #1;
        cmp_all("reset");
        reset_n = 1'b1;

        // EX/MEM forward: r3=5 then r3 + 7
        issue(3'b010, 0, 5, 0, 0, 1, 0, 1, 5'd3, 0);
        tick("wr_r3");
        issue(3'b010, 5'd3, 0, 5'd6, 7, 0, 0, 1, 5'd7, 0);
        tick("fwd_exmem");
        check("fwd_exmem_val", alu_result_out, 32'd12);

        // EX/MEM beats MEM/WB; r0 is never forwarded
        issue(3'b010, 0, 9, 0, 0, 1, 0, 1, 5'd4, 0);
        tick("wr_r4");
        issue(3'b010, 5'd4, 0, 0, 0, 1, 1, 1, 5'd0, 0);
        memwb_reg_write_in = 1; memwb_write_reg_in = 4;
        memwb_write_data_in = 2;
        tick("prio");
        check("prio_val", alu_result_out, 32'd10);
        issue(3'b010, 5'd0, 3, 0, 0, 1, 1, 0, 5'd0, 0);
        memwb_reg_write_in = 1; memwb_write_reg_in = 0;
        memwb_write_data_in = 2;
        tick("r0");
        check("r0_val", alu_result_out, 32'd4);

        // BEQ taken, then the wrong-path instruction is killed
        issue(3'b110, 5'd1, 7, 5'd2, 7, 0, 4, 0, 5'd0, 1);
        tick("beq");
        check("beq_taken", 32'(branch_taken_out), 32'd1);
        check("beq_target", branch_target_out, 32'h110);
        issue(3'b010, 5'd1, 1, 5'd2, 1, 0, 4, 1, 5'd9, 1);
        tick("kill");
        check("kill_rw", 32'(reg_write_out), 32'd0);
        check("kill_bt", 32'(branch_taken_out), 32'd0);

        // signed compare and wrapping subtract
        issue(3'b111, 5'd1, 32'hFFFF_FFFF, 0, 0, 1, 1, 1, 5'd8, 0);
        tick("slt");
        check("slt_val", alu_result_out, 32'd1);
        issue(3'b110, 5'd1, 0, 0, 0, 1, 1, 1, 5'd8, 0);
        tick("sub");
        check("sub_val", alu_result_out, 32'hFFFF_FFFF);

`ifdef EX_MUL_EN
        issue(3'b010, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick("nop");
        mul_run(32'd6, 32'd7);
        issue(3'b010, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick("nop2");
        mul_run(32'hFFFF_FFFF, 32'd2);
        issue(3'b010, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick("nop3");
        mul_run($urandom, $urandom);
        // abort a multiply partway through
        issue(3'b011, 5'd1, 3, 5'd2, 5, 0, 0, 1, 5'd5, 0);
        repeat (11) @(posedge clk);
        #1;
        do_reset("mul_abort");
        issue(3'b010, 0, 20, 0, 0, 1, 22, 1, 5'd6, 0);
        tick("post_abort");
        check("post_abort_val", alu_result_out, 32'd42);
`else
        issue(3'b011, 5'd1, 6, 5'd2, 7, 0, 0, 1, 5'd5, 0);
        tick("mul_off");
        check("mul_off_val", alu_result_out, 32'd0);
        check("mul_off_rw", 32'(reg_write_out), 32'd1);
`endif

        // mid-stream reset
        do_reset("reset2");

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            op = 3'($urandom_range(0, 7));
`ifdef EX_MUL_EN
            if (op == 3'b011)
                op = 3'b010;
`endif
            alu_ctrl_in = op;
            rs_in = 5'($urandom_range(0, 3));
            rt_in = 5'($urandom_range(0, 3));
            rd_in = 5'($urandom_range(0, 3));
            rd1_in = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 9))
                                                 : $urandom;
            rd2_in = ($urandom_range(0, 1) == 0) ? rd1_in : $urandom;
            sign_ext_imm_in = ($urandom_range(0, 1) == 0)
                ? 32'($urandom_range(0, 15)) : $urandom;
            pc_plus4_in = $urandom;
            reg_dst_in = 1'($urandom_range(0, 1));
            alu_src_in = 1'($urandom_range(0, 1));
            reg_write_in = 1'($urandom_range(0, 1));
            mem_to_reg_in = 1'($urandom_range(0, 1));
            mem_read_in = 1'($urandom_range(0, 1));
            mem_write_in = 1'($urandom_range(0, 1));
            branch_in = ($urandom_range(0, 4) == 0);
            memwb_reg_write_in = 1'($urandom_range(0, 1));
            memwb_write_reg_in = 5'($urandom_range(0, 3));
            memwb_write_data_in = $urandom;
            tick("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
